// File: rtl/router_mp.sv
`default_nettype none
// ============================================================================
// Module   : router_mp
// Purpose  : Store-and-forward packet router. Byte-serial packets
//            (DA, LEN, LEN payload bytes, CSUM) are buffered and checked
//            for length, checksum and destination. Good packets are then
//            forwarded to output lane DA with a valid/ready handshake.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-high reset
//            dut_inp    - input byte
//            inp_valid  - input byte valid, held high for a whole packet
//            dut_outp   - NUM_PORTS output lanes, lane p = [p*DATA_W +: DATA_W]
//            outp_valid - per-lane byte valid
//            outp_ready - per-lane consumer ready
//            busy       - checking or forwarding; input is not accepted
//            error      - one-cycle error code (0 none, 1 bad DA, 2 bad LEN,
//                         3 checksum, 4 truncation, 5 input while busy)
// Options  : ROUTER_STRIP_HDR_EN - when defined, only the payload bytes are
//            forwarded. Otherwise DA, LEN, payload and CSUM are forwarded.
// Revision : 1.0 - initial release
// ============================================================================
module router_mp #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_LEN   = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           dut_inp,
    input  logic                        inp_valid,
    output logic [NUM_PORTS*DATA_W-1:0] dut_outp,
    output logic [NUM_PORTS-1:0]        outp_valid,
    input  logic [NUM_PORTS-1:0]        outp_ready,
    output logic                        busy,
    output logic [3:0]                  error
);

    localparam int c_DEPTH  = MAX_LEN + 3;
    localparam int c_IDX_W  = $clog2(c_DEPTH);
    localparam int c_PORT_W = $clog2(NUM_PORTS);

    localparam logic [DATA_W-1:0] c_MAX_LEN = DATA_W'(MAX_LEN);

    // The buffer holds DA at 0, LEN at 1, payload at 2..LEN+1 and CSUM at
    // LEN+2. The forwarded window is [c_RD_FIRST, LEN + c_RD_TAIL].
`ifdef ROUTER_STRIP_HDR_EN
    localparam logic [c_IDX_W-1:0] c_RD_FIRST = c_IDX_W'(2);
    localparam logic [c_IDX_W-1:0] c_RD_TAIL  = c_IDX_W'(1);
`else
    localparam logic [c_IDX_W-1:0] c_RD_FIRST = c_IDX_W'(0);
    localparam logic [c_IDX_W-1:0] c_RD_TAIL  = c_IDX_W'(2);
`endif

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RX_LEN  = 3'd1;
    localparam logic [2:0] c_S_RX_PAY  = 3'd2;
    localparam logic [2:0] c_S_RX_CSUM = 3'd3;
    localparam logic [2:0] c_S_CHECK   = 3'd4;
    localparam logic [2:0] c_S_FWD     = 3'd5;
    localparam logic [2:0] c_S_DISCARD = 3'd6;

    localparam logic [3:0] c_E_NONE  = 4'd0;
    localparam logic [3:0] c_E_DA    = 4'd1;
    localparam logic [3:0] c_E_LEN   = 4'd2;
    localparam logic [3:0] c_E_CSUM  = 4'd3;
    localparam logic [3:0] c_E_TRUNC = 4'd4;
    localparam logic [3:0] c_E_BUSY  = 4'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_IDX_W-1:0] r_wr_idx;
    logic [c_IDX_W-1:0] r_rd_idx;
    logic [DATA_W-1:0]  r_rem;
    logic [DATA_W-1:0]  r_xor;
    logic [DATA_W-1:0]  r_da;
    logic [DATA_W-1:0]  r_len;
    logic [DATA_W-1:0]  r_csum;
    logic               r_skip;
    logic [DATA_W-1:0]  r_buf [0:c_DEPTH-1];

    logic [2:0]         w_state;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [DATA_W-1:0]  w_rem;
    logic [DATA_W-1:0]  w_xor;
    logic [DATA_W-1:0]  w_da;
    logic [DATA_W-1:0]  w_len;
    logic [DATA_W-1:0]  w_csum;
    logic               w_skip;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_wr_addr;
    logic [3:0]         w_error;

    logic               w_busy;
    logic               w_fwd;
    logic [c_PORT_W-1:0] w_port;
    logic               w_ready_sel;
    logic [DATA_W-1:0]  w_rd_data;
    logic [c_IDX_W-1:0] w_rd_last;
    logic               w_da_bad;

    assign w_busy      = (r_state == c_S_CHECK) || (r_state == c_S_FWD);
    assign w_fwd       = (r_state == c_S_FWD);
    assign w_port      = r_da[c_PORT_W-1:0];
    assign w_ready_sel = outp_ready[w_port];
    assign w_rd_data   = r_buf[r_rd_idx];
    assign w_rd_last   = c_IDX_W'(r_len) + c_RD_TAIL;
    assign w_da_bad    = (32'(r_da) >= 32'(NUM_PORTS));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_wr_idx  = r_wr_idx;
        w_rd_idx  = r_rd_idx;
        w_rem     = r_rem;
        w_xor     = r_xor;
        w_da      = r_da;
        w_len     = r_len;
        w_csum    = r_csum;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_idx;
        w_error   = c_E_NONE;

        // An input packet that collides with a busy router is lost in full.
        // Its remaining bytes are ignored until inp_valid drops.
        if (!inp_valid) begin
            w_skip = 1'b0;
        end else if (w_busy) begin
            w_skip = 1'b1;
        end else begin
            w_skip = r_skip;
        end

        case (r_state)
            c_S_IDLE: begin
                w_wr_addr = '0;
                w_wr_idx  = '0;
                if (inp_valid && !r_skip) begin
                    w_da     = dut_inp;
                    w_xor    = dut_inp;
                    w_wr_en  = 1'b1;
                    w_wr_idx = c_IDX_W'(1);
                    w_state  = c_S_RX_LEN;
                end
            end

            c_S_RX_LEN: begin
                if (!inp_valid) begin
                    w_error = c_E_TRUNC;
                    w_state = c_S_IDLE;
                end else if ((dut_inp == '0) || (dut_inp > c_MAX_LEN)) begin
                    w_error = c_E_LEN;
                    w_state = c_S_DISCARD;
                end else begin
                    w_len    = dut_inp;
                    w_rem    = dut_inp;
                    w_xor    = r_xor ^ dut_inp;
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_wr_idx + c_IDX_W'(1);
                    w_state  = c_S_RX_PAY;
                end
            end

            c_S_RX_PAY: begin
                if (!inp_valid) begin
                    w_error = c_E_TRUNC;
                    w_state = c_S_IDLE;
                end else begin
                    w_xor    = r_xor ^ dut_inp;
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_wr_idx + c_IDX_W'(1);
                    w_rem    = r_rem - DATA_W'(1);
                    if (r_rem == DATA_W'(1)) begin
                        w_state = c_S_RX_CSUM;
                    end
                end
            end

            c_S_RX_CSUM: begin
                if (!inp_valid) begin
                    w_error = c_E_TRUNC;
                    w_state = c_S_IDLE;
                end else begin
                    w_csum  = dut_inp;
                    w_wr_en = 1'b1;
                    w_state = c_S_CHECK;
                end
            end

            c_S_CHECK: begin
                // Checksum is judged before the destination; either drop
                // outranks a simultaneous busy violation.
                if (r_xor != r_csum) begin
                    w_error = c_E_CSUM;
                    w_state = c_S_IDLE;
                end else if (w_da_bad) begin
                    w_error = c_E_DA;
                    w_state = c_S_IDLE;
                end else begin
                    w_rd_idx = c_RD_FIRST;
                    w_state  = c_S_FWD;
                    if (inp_valid) begin
                        w_error = c_E_BUSY;
                    end
                end
            end

            c_S_FWD: begin
                if (inp_valid) begin
                    w_error = c_E_BUSY;
                end
                if (w_ready_sel) begin
                    if (r_rd_idx == w_rd_last) begin
                        w_state = c_S_IDLE;
                    end else begin
                        w_rd_idx = r_rd_idx + c_IDX_W'(1);
                    end
                end
            end

            c_S_DISCARD: begin
                if (!inp_valid) begin
                    w_state = c_S_IDLE;
                end
            end

            default: begin
                w_state = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_rem    <= '0;
            r_xor    <= '0;
            r_da     <= '0;
            r_len    <= '0;
            r_csum   <= '0;
            r_skip   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_wr_idx <= w_wr_idx;
            r_rd_idx <= w_rd_idx;
            r_rem    <= w_rem;
            r_xor    <= w_xor;
            r_da     <= w_da;
            r_len    <= w_len;
            r_csum   <= w_csum;
            r_skip   <= w_skip;
        end
    end

    // Packet buffer; contents are meaningless outside the index window,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_buf[w_wr_addr] <= dut_inp;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = w_busy;
    assign error = reset ? c_E_NONE : w_error;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
            localparam logic [c_PORT_W-1:0] c_P = c_PORT_W'(p);
            logic w_sel;
            assign w_sel                        = w_fwd && (w_port == c_P);
            assign outp_valid[p]                = w_sel;
            assign dut_outp[p*DATA_W +: DATA_W] = w_sel ? w_rd_data : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_router_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_mp
// Purpose  : Self-checking bench for router_mp. Forwarded bytes are
//            predicted into a scoreboard queue when a packet is driven
//            and popped on every output handshake. Error pulses are
//            logged and compared per packet against a vector table.
//            Hand sequences cover latency, truncation, backpressure,
//            busy violation and reset during forward.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_mp;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int ML = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   dut_inp = '0;
    logic            inp_valid = 1'b0;
    logic [NP*DW-1:0] dut_outp;
    logic [NP-1:0]   outp_valid;
    logic [NP-1:0]   outp_ready = '1;
    logic            busy;
    logic [3:0]      error;

    always #5 clk = ~clk;

    router_mp #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_LEN(ML)) dut (
        .clk        (clk),
        .reset      (reset),
        .dut_inp    (dut_inp),
        .inp_valid  (inp_valid),
        .dut_outp   (dut_outp),
        .outp_valid (outp_valid),
        .outp_ready (outp_ready),
        .busy       (busy),
        .error      (error)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [3:0] port;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic [7:0] da;
        logic [7:0] len;
        logic [7:0] seed;
        logic [7:0] flip;
        logic [3:0] err;
    } vec_t;

    exp_t       exp_q[$];
    logic [3:0] err_q[$];
    logic [7:0] pkt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor: scoreboard pops, idle-lane and hold-stability checks
    // ------------------------------------------------------------------
    logic [NP-1:0]    prev_valid = '0;
    logic [NP-1:0]    prev_ready = '0;
    logic [NP*DW-1:0] prev_data  = '0;
    logic [7:0]       m_lane;
    exp_t             m_e;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = '0;
            prev_ready = '0;
            prev_data  = '0;
        end else begin
            if ($countones(outp_valid) > 1)
                check("one_lane", 32'(outp_valid), 32'(outp_valid & -outp_valid));
            for (int p = 0; p < NP; p++) begin
                m_lane = dut_outp[p*DW +: DW];
                if (!outp_valid[p] && (m_lane !== 8'h00))
                    check("idle_lane", 32'(m_lane), 32'h0);
                if (prev_valid[p] && !prev_ready[p]) begin
                    check("hold_valid", 32'(outp_valid[p]), 32'h1);
                    check("hold_data", 32'(m_lane), 32'(prev_data[p*DW +: DW]));
                end
                if (outp_valid[p] && outp_ready[p]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(m_lane), 32'hFFFF_FFFF);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("out_port", 32'(p), 32'(m_e.port));
                        check("out_data", 32'(m_lane), 32'(m_e.data));
                    end
                end
            end
            if (error !== 4'd0) err_q.push_back(error);
            prev_valid = outp_valid;
            prev_ready = outp_ready;
            prev_data  = dut_outp;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        dut_inp   = b;
        inp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inp();
        dut_inp   = '0;
        inp_valid = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
        idle_inp();
    endtask

    // Predict the forwarded byte stream of the packet currently in pkt.
    task automatic push_exp(input logic [3:0] port);
        exp_t e;
`ifdef ROUTER_STRIP_HDR_EN
        for (int i = 2; i < pkt.size() - 1; i++) begin
`else
        for (int i = 0; i < pkt.size(); i++) begin
`endif
            e.port = port;
            e.data = pkt[i];
            exp_q.push_back(e);
        end
    endtask

    // Builds DA, LEN, payload, CSUM^flip. An illegal LEN is followed by
    // three junk bytes that must be discarded.
    task automatic build_pkt(input logic [7:0] da, input logic [7:0] len,
                             input logic [7:0] seed, input logic [7:0] flip);
        logic [7:0] x;
        pkt.delete();
        pkt.push_back(da);
        pkt.push_back(len);
        if (len == 8'd0 || int'(len) > ML) begin
            for (int i = 0; i < 3; i++) pkt.push_back(seed + 8'(i));
        end else begin
            for (int i = 0; i < int'(len); i++) pkt.push_back(seed + 8'(i * 29));
            x = 8'h00;
            foreach (pkt[i]) x = x ^ pkt[i];
            pkt.push_back(x ^ flip);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        repeat (3) @(posedge clk);
        while ((busy !== 1'b0 || exp_q.size() != 0) && k < 400) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        check({name, "_not_busy"}, 32'(busy), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] observed_err();
        if (err_q.size() == 0) return 4'd0;
        if (err_q.size() == 1) return err_q[0];
        return 4'hF;
    endfunction

    task automatic wait_valid(input int p, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (outp_valid[p] !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid_seen"}, 32'(outp_valid[p]), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t vt[12];
    logic [7:0] b3;

    initial begin
        vt[0]  = '{8'h02, 8'h03, 8'h11, 8'h00, 4'd0};
        vt[1]  = '{8'h00, 8'h01, 8'h5A, 8'h00, 4'd0};
        vt[2]  = '{8'h03, 8'h02, 8'hF0, 8'h00, 4'd0};
        vt[3]  = '{8'h01, 8'h40, 8'h07, 8'h00, 4'd0};
        vt[4]  = '{8'h02, 8'h05, 8'h33, 8'h01, 4'd3};
        vt[5]  = '{8'h05, 8'h01, 8'hAA, 8'h00, 4'd1};
        vt[6]  = '{8'h04, 8'h02, 8'h10, 8'h00, 4'd1};
        vt[7]  = '{8'h07, 8'h02, 8'h10, 8'h80, 4'd3};
        vt[8]  = '{8'h01, 8'h00, 8'h55, 8'h00, 4'd2};
        vt[9]  = '{8'h01, 8'h41, 8'h55, 8'h00, 4'd2};
        vt[10] = '{8'h01, 8'hFF, 8'h55, 8'h00, 4'd2};
        vt[11] = '{8'h01, 8'h01, 8'h00, 8'h00, 4'd0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(outp_valid), 32'h0);
        check("rst_data",  dut_outp,        32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_error", 32'(error),      32'h0);
        @(posedge clk);
        #1;

        // Good packet to port 2: latency from the CSUM edge.
        err_q.delete();
        pkt = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
        push_exp(4'd2);
        send_pkt();
        @(negedge clk);
        check("lat_check_busy",  32'(busy),       32'h1);
        check("lat_check_valid", 32'(outp_valid), 32'h0);
        @(negedge clk);
        check("lat_first_valid", 32'(outp_valid), 32'h4);
`ifdef ROUTER_STRIP_HDR_EN
        check("lat_first_byte",  32'(dut_outp[2*DW +: DW]), 32'h11);
`else
        check("lat_first_byte",  32'(dut_outp[2*DW +: DW]), 32'h02);
`endif
        wait_done("good_p2");
        check("good_p2_err", 32'(observed_err()), 32'h0);

        // Bad checksum: error 3 in the single CHECK cycle.
        err_q.delete();
        pkt = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send_pkt();
        @(negedge clk);
        check("csum_busy",  32'(busy),  32'h1);
        check("csum_error", 32'(error), 32'h3);
        @(negedge clk);
        check("csum_busy_end",  32'(busy),       32'h0);
        check("csum_error_end", 32'(error),      32'h0);
        check("csum_no_valid",  32'(outp_valid), 32'h0);
        wait_done("csum");

        // Truncation after 2 of 3 payload bytes, then recovery.
        err_q.delete();
        pkt = '{8'h01, 8'h03, 8'h11, 8'h22};
        send_pkt();
        @(negedge clk);
        check("trunc_error", 32'(error), 32'h4);
        @(negedge clk);
        check("trunc_error_end", 32'(error), 32'h0);
        check("trunc_busy",      32'(busy),  32'h0);
        @(posedge clk);
        #1;
        err_q.delete();
        pkt = '{8'h01, 8'h01, 8'h77, 8'h77};
        push_exp(4'd1);
        send_pkt();
        wait_done("after_trunc");
        check("after_trunc_err", 32'(observed_err()), 32'h0);

        // Backpressure on port 1: third output byte held for 4 cycles.
        err_q.delete();
        pkt = '{8'h01, 8'h05, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00};
        pkt[7] = 8'h01 ^ 8'h05 ^ 8'hA1 ^ 8'hA2 ^ 8'hA3 ^ 8'hA4 ^ 8'hA5;
`ifdef ROUTER_STRIP_HDR_EN
        b3 = pkt[4];
`else
        b3 = pkt[2];
`endif
        push_exp(4'd1);
        send_pkt();
        wait_valid(1, "bp");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        outp_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(outp_valid[1]),      32'h1);
            check("bp_hold_byte",  32'(dut_outp[DW +: DW]), 32'(b3));
            @(posedge clk);
            #1;
        end
        outp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_release_byte", 32'(dut_outp[DW +: DW]), 32'(b3));
        wait_done("bp");
        check("bp_err", 32'(observed_err()), 32'h0);

        // Busy violation during forward to port 3.
        err_q.delete();
        build_pkt(8'h03, 8'h04, 8'h61, 8'h00);
        push_exp(4'd3);
        send_pkt();
        wait_valid(3, "viol");
        @(posedge clk);
        #1;
        dut_inp   = 8'hEE;
        inp_valid = 1'b1;
        @(negedge clk);
        check("viol_error_1", 32'(error), 32'h5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("viol_error_2", 32'(error), 32'h5);
        @(posedge clk);
        #1;
        idle_inp();
        wait_done("viol");
        err_q.delete();

        // Reset in the middle of a forward to port 0.
        build_pkt(8'h00, 8'h08, 8'h20, 8'h00);
        push_exp(4'd0);
        send_pkt();
        wait_valid(0, "rstfwd");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        err_q.delete();
        @(negedge clk);
        check("rstfwd_valid", 32'(outp_valid), 32'h0);
        check("rstfwd_data",  dut_outp,        32'h0);
        check("rstfwd_busy",  32'(busy),       32'h0);
        check("rstfwd_error", 32'(error),      32'h0);
        @(posedge clk);
        #1;
        check("rstfwd_err_log", 32'(observed_err()), 32'h0);

        // Table-driven packets.
        for (int i = 0; i < 12; i++) begin
            err_q.delete();
            build_pkt(vt[i].da, vt[i].len, vt[i].seed, vt[i].flip);
            if (vt[i].err == 4'd0) push_exp(vt[i].da[3:0]);
            send_pkt();
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), 32'(observed_err()), 32'(vt[i].err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
